// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-master memory bus arbiter: FSM state
// encodings, master-select codes, reset levels and common constants.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam logic        ARB_SEL_IF = 1'b0;
  localparam logic        ARB_SEL_D  = 1'b1;
  localparam logic [3:0]  BE_ALL     = 4'hF;
  localparam logic        RstEnable  = 1'b1;
  localparam logic        RstDisable = 1'b0;
  localparam logic [31:0] ZeroWord   = 32'h0000_0000;

  // Data wins unless it took the previous slot and a fetch is waiting.
  function automatic logic d_wins(input logic i_req, input logic d_req, input logic last_d);
    return d_req && !(last_d && i_req);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundles the fetch, data and slave handshakes of the memory bus arbiter.
// The slave modport is the arbiter's view; master is the core/memory side.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ack;
  logic              d_req;
  logic              d_we;
  logic [3:0]        d_sel;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              s_req;
  logic              s_we;
  logic [3:0]        s_sel;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic [DATA_W-1:0] s_rdata;
  logic              s_ack;
  logic              stallreq_if;
  logic              stallreq_mem;
  logic              bus_err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_sel, d_addr, d_wdata, s_rdata, s_ack,
    output i_rdata, i_ack, d_rdata, d_ack, s_req, s_we, s_sel, s_addr, s_wdata,
           stallreq_if, stallreq_mem, bus_err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_sel, d_addr, d_wdata, s_rdata, s_ack,
    input  i_rdata, i_ack, d_rdata, d_ack, s_req, s_we, s_sel, s_addr, s_wdata,
           stallreq_if, stallreq_mem, bus_err
  );
endinterface

// File: rtl/mem_arb_watchdog.sv
// Slave-ack watchdog for the memory bus arbiter; present only when
// ARB_TIMEOUT_EN is defined.
`ifdef ARB_TIMEOUT_EN
module mem_arb_watchdog
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ack,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] cnt_r;

  // Count grant cycles without an ack; cleared whenever no grant is active.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (!active) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (!ack) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = active && !ack && (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
endmodule
`endif

// File: rtl/mem_bus_arbiter.sv
// Two-master (fetch/data) arbiter for a single memory slave port.
// Optional slave-ack timeout enabled with ARB_TIMEOUT_EN.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic              clk,
  input logic              rst,
  mem_bus_arbiter_if.slave bus
);
  arb_state_e        state_r;
  logic              last_d_r;
  logic              s_req_r;
  logic              s_we_r;
  logic [3:0]        s_sel_r;
  logic [ADDR_W-1:0] s_addr_r;
  logic [DATA_W-1:0] s_wdata_r;
  logic [DATA_W-1:0] i_rdata_r;
  logic [DATA_W-1:0] d_rdata_r;
  logic              i_ack_r;
  logic              d_ack_r;
  logic              bus_err_r;
  logic              in_gnt_s;
  logic              expired_s;
  logic              grant_d_s;

  assign in_gnt_s  = (state_r == ST_GNT_I) || (state_r == ST_GNT_D);
  assign grant_d_s = d_wins(bus.i_req, bus.d_req, last_d_r);

`ifdef ARB_TIMEOUT_EN
  mem_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .active  (in_gnt_s),
    .ack     (bus.s_ack),
    .expired (expired_s)
  );
`else
  assign expired_s = 1'b0;
`endif

  // Arbitration FSM: grant, wait for slave ack (or abort), one-cycle response.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_r   <= ST_IDLE;
      last_d_r  <= 1'b0;
      s_req_r   <= 1'b0;
      s_we_r    <= 1'b0;
      s_sel_r   <= 4'h0;
      s_addr_r  <= {ADDR_W{1'b0}};
      s_wdata_r <= {DATA_W{1'b0}};
      i_rdata_r <= {DATA_W{1'b0}};
      d_rdata_r <= {DATA_W{1'b0}};
      i_ack_r   <= 1'b0;
      d_ack_r   <= 1'b0;
      bus_err_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_d_s) begin
            state_r   <= ST_GNT_D;
            s_req_r   <= 1'b1;
            s_we_r    <= bus.d_we;
            s_sel_r   <= bus.d_sel;
            s_addr_r  <= bus.d_addr;
            s_wdata_r <= bus.d_wdata;
          end else if (bus.i_req) begin
            state_r   <= ST_GNT_I;
            s_req_r   <= 1'b1;
            s_we_r    <= 1'b0;
            s_sel_r   <= BE_ALL;
            s_addr_r  <= bus.i_addr;
            s_wdata_r <= {DATA_W{1'b0}};
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GNT_I, ST_GNT_D: begin
          if (bus.s_ack || expired_s) begin
            // An abort completes like an ack but returns zero data and flags it.
            state_r   <= ST_RESP;
            s_req_r   <= 1'b0;
            i_ack_r   <= (state_r == ST_GNT_I);
            d_ack_r   <= (state_r == ST_GNT_D);
            bus_err_r <= !bus.s_ack;
            last_d_r  <= (state_r == ST_GNT_D) ? ARB_SEL_D : ARB_SEL_IF;
            if (state_r == ST_GNT_I) begin
              i_rdata_r <= bus.s_ack ? bus.s_rdata : {DATA_W{1'b0}};
            end else begin
              d_rdata_r <= bus.s_ack ? bus.s_rdata : {DATA_W{1'b0}};
            end
          end else begin
            state_r <= state_r;
          end
        end
        ST_RESP: begin
          state_r   <= ST_IDLE;
          i_ack_r   <= 1'b0;
          d_ack_r   <= 1'b0;
          bus_err_r <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.s_req        = s_req_r;
  assign bus.s_we         = s_we_r;
  assign bus.s_sel        = s_sel_r;
  assign bus.s_addr       = s_addr_r;
  assign bus.s_wdata      = s_wdata_r;
  assign bus.i_rdata      = i_rdata_r;
  assign bus.d_rdata      = d_rdata_r;
  assign bus.i_ack        = i_ack_r;
  assign bus.d_ack        = d_ack_r;
  assign bus.bus_err      = bus_err_r;
  assign bus.stallreq_if  = bus.i_req & ~i_ack_r;
  assign bus.stallreq_mem = bus.d_req & ~d_ack_r;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus random
// request/wait-state traffic against a transaction-level arbitration model.
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model state: pending requests, who had the last slot, expected payloads.
  bit          i_pend, d_pend, last_d_m;
  logic [31:0] exp_i_addr, exp_d_addr, exp_d_wdata, exp_i_rdata, exp_d_rdata;
  logic        exp_d_we;
  logic [3:0]  exp_d_sel;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic raise_i(input logic [31:0] a);
    bus.i_req = 1'b1; bus.i_addr = a;
    i_pend = 1'b1; exp_i_addr = a;
  endtask

  task automatic raise_d(input logic we, input logic [3:0] sel, input logic [31:0] a, input logic [31:0] wd);
    bus.d_req = 1'b1; bus.d_we = we; bus.d_sel = sel; bus.d_addr = a; bus.d_wdata = wd;
    d_pend = 1'b1; exp_d_we = we; exp_d_sel = sel; exp_d_addr = a; exp_d_wdata = wd;
  endtask

  task automatic clear_model();
    i_pend = 1'b0; d_pend = 1'b0; last_d_m = 1'b0;
    exp_i_rdata = 32'd0; exp_d_rdata = 32'd0;
  endtask

  // One arbitration slot starting in IDLE: grant, wait states, ack, response.
  task automatic round(input int wait_n, input logic [31:0] rd);
    bit win_d;
    if (!i_pend && !d_pend) begin
      bus.s_ack = 1'b1; bus.s_rdata = rd;
      step();
      bus.s_ack = 1'b0;
      chk("idle_s_req", bus.s_req, 32'd0);
      chk("idle_i_ack", bus.i_ack, 32'd0);
      chk("idle_d_ack", bus.d_ack, 32'd0);
      chk("idle_i_rdata", bus.i_rdata, exp_i_rdata);
      return;
    end
    win_d = d_pend && !(last_d_m && i_pend);
    step();
    chk("gnt_s_req", bus.s_req, 32'd1);
    chk("gnt_s_we", bus.s_we, win_d ? {31'd0, exp_d_we} : 32'd0);
    chk("gnt_s_sel", bus.s_sel, win_d ? {28'd0, exp_d_sel} : 32'h0000_000F);
    chk("gnt_s_addr", bus.s_addr, win_d ? exp_d_addr : exp_i_addr);
    chk("gnt_s_wdata", bus.s_wdata, win_d ? exp_d_wdata : 32'd0);
    chk("gnt_acks", {30'd0, bus.i_ack, bus.d_ack}, 32'd0);
    chk("gnt_stall_if", bus.stallreq_if, {31'd0, i_pend});
    chk("gnt_stall_mem", bus.stallreq_mem, {31'd0, d_pend});
    if (win_d) begin
      bus.d_addr = $urandom; bus.d_wdata = $urandom; bus.d_sel = 4'($urandom); bus.d_we = ~bus.d_we;
    end else begin
      bus.i_addr = $urandom;
    end
    for (int k = 0; k < wait_n; k++) begin
      step();
      chk("wait_s_req", bus.s_req, 32'd1);
      chk("wait_s_addr", bus.s_addr, win_d ? exp_d_addr : exp_i_addr);
      chk("wait_acks", {30'd0, bus.i_ack, bus.d_ack}, 32'd0);
    end
    bus.s_ack = 1'b1; bus.s_rdata = rd;
    step();
    bus.s_ack = 1'b0; bus.s_rdata = $urandom;
    if (win_d) exp_d_rdata = rd; else exp_i_rdata = rd;
    chk("ack_s_req", bus.s_req, 32'd0);
    chk("ack_i_ack", bus.i_ack, {31'd0, !win_d});
    chk("ack_d_ack", bus.d_ack, {31'd0, win_d});
    chk("ack_i_rdata", bus.i_rdata, exp_i_rdata);
    chk("ack_d_rdata", bus.d_rdata, exp_d_rdata);
    chk("ack_bus_err", bus.bus_err, 32'd0);
    chk("ack_stall_if", bus.stallreq_if, {31'd0, win_d && i_pend});
    chk("ack_stall_mem", bus.stallreq_mem, {31'd0, !win_d && d_pend});
    last_d_m = win_d;
    if (win_d) begin bus.d_req = 1'b0; d_pend = 1'b0; end
    else begin bus.i_req = 1'b0; i_pend = 1'b0; end
    bus.s_ack = 1'($urandom_range(0, 1));
    step();
    bus.s_ack = 1'b0;
    chk("resp_s_req", bus.s_req, 32'd0);
    chk("resp_acks", {30'd0, bus.i_ack, bus.d_ack}, 32'd0);
    chk("resp_i_rdata", bus.i_rdata, exp_i_rdata);
    chk("resp_d_rdata", bus.d_rdata, exp_d_rdata);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0010;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_sel = 4'hF; bus.d_addr = 32'h0000_0020;
    bus.d_wdata = 32'h1111_2222; bus.s_ack = 1'b0; bus.s_rdata = 32'h5555_AAAA;
    clear_model();

    // Reset held with both requests asserted.
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("rst_s_req", bus.s_req, 32'd0);
      chk("rst_acks", {30'd0, bus.i_ack, bus.d_ack}, 32'd0);
      chk("rst_i_rdata", bus.i_rdata, 32'd0);
      chk("rst_d_rdata", bus.d_rdata, 32'd0);
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0; rst = 1'b0;
    step();

    // Single fetch with two wait states.
    raise_i(32'h0000_0004);
    round(2, 32'h3401_1100);

    // Contention: data first, fetch immediately after.
    raise_i(32'h0000_0008);
    raise_d(1'b1, 4'h3, 32'h0000_0100, 32'hDEAD_BEEF);
    round(0, 32'h0BAD_F00D);
    round(1, 32'h2402_0022);

    // Alternation with data continuously reissued and fetch pending.
    for (int r = 0; r < 4; r++) begin
      if (!i_pend) raise_i(32'h0000_0200 + 32'(r * 4));
      if (!d_pend) raise_d(1'b0, 4'hF, 32'h0000_0400 + 32'(r * 4), 32'd0);
      chk("alt_order", {31'd0, d_pend && !(last_d_m && i_pend)}, {31'd0, (r % 2) == 0});
      round(r % 3, $urandom);
    end
    if (i_pend) round(0, $urandom);

    // Random traffic.
    for (int r = 0; r < 80; r++) begin
      if (!i_pend && $urandom_range(0, 2) != 0) raise_i($urandom);
      if (!d_pend && $urandom_range(0, 2) != 0)
        raise_d(1'($urandom), 4'($urandom), $urandom, $urandom);
      round($urandom_range(0, 3), $urandom);
    end
    while (i_pend || d_pend) round(0, $urandom);

    // Reset while a data grant is waiting, coinciding with s_ack.
    raise_d(1'b0, 4'hF, 32'h0000_0200, 32'd0);
    step();
    chk("mid_gnt_s_req", bus.s_req, 32'd1);
    rst = 1'b1; bus.s_ack = 1'b1; bus.s_rdata = 32'h7777_7777;
    step();
    rst = 1'b0; bus.s_ack = 1'b0; bus.d_req = 1'b0;
    clear_model();
    chk("mid_rst_s_req", bus.s_req, 32'd0);
    chk("mid_rst_d_ack", bus.d_ack, 32'd0);
    chk("mid_rst_d_rdata", bus.d_rdata, 32'd0);
    chk("mid_rst_i_rdata", bus.i_rdata, 32'd0);
    round(0, 32'h6666_6666);
    raise_i(32'h0000_0030);
    round(1, 32'h1357_9BDF);

`ifdef ARB_TIMEOUT_EN
    // Slave never acks a fetch: abort 16 cycles after the grant.
    raise_i(32'h0000_0040);
    step();
    chk("to_gnt_s_req", bus.s_req, 32'd1);
    for (int k = 1; k < 16; k++) begin
      step();
      chk("to_wait_i_ack", bus.i_ack, 32'd0);
      chk("to_wait_bus_err", bus.bus_err, 32'd0);
    end
    step();
    chk("to_i_ack", bus.i_ack, 32'd1);
    chk("to_bus_err", bus.bus_err, 32'd1);
    chk("to_i_rdata", bus.i_rdata, 32'd0);
    chk("to_s_req", bus.s_req, 32'd0);
    chk("to_d_ack", bus.d_ack, 32'd0);
    exp_i_rdata = 32'd0; last_d_m = 1'b0;
    bus.i_req = 1'b0; i_pend = 1'b0;
    bus.s_ack = 1'b1;
    step();
    bus.s_ack = 1'b0;
    chk("to_late_bus_err", bus.bus_err, 32'd0);
    chk("to_late_i_ack", bus.i_ack, 32'd0);
    raise_i(32'h0000_0044);
    round(1, 32'h1234_5678);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
